// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, opcodes, ALU codes and default halt word for the sequencer
package seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;
endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: run/instruction inputs and control strobes of the sequencer
interface multicycle_sequencer_if;
    logic        run;
    logic [15:0] instr;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        reg_dst;
    logic        alu_src;
    logic [3:0]  alu_control;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    modport master (
        output run, instr,
        input  ir_write, pc_write, reg_write, reg_dst, alu_src, alu_control, busy, halted, instr_count
    );

    modport slave (
        input  run, instr,
        output ir_write, pc_write, reg_write, reg_dst, alu_src, alu_control, busy, halted, instr_count
    );
endinterface

// File: rtl/seq_decode.sv
// seq_decode: combinational opcode to register-destination / ALU control decode
module seq_decode
    import seq_pkg::*;
(
    input  logic [3:0] op_i,
    output logic       valid_o,
    output logic       reg_dst_o,
    output logic       alu_src_o,
    output logic [3:0] alu_control_o
);
    // R-type ops write IR[7:6]; addi writes IR[9:8] with the immediate; the upper half is undefined
    always_comb begin
        valid_o       = 1'b1;
        reg_dst_o     = 1'b1;
        alu_src_o     = 1'b0;
        alu_control_o = ALU_ADD;
        case (op_i)
            OP_ADD:  alu_control_o = ALU_ADD;
            OP_SUB:  alu_control_o = ALU_SUB;
            OP_AND:  alu_control_o = ALU_AND;
            OP_OR:   alu_control_o = ALU_OR;
            OP_NOR:  alu_control_o = ALU_NOR;
            OP_NAND: alu_control_o = ALU_NAND;
            OP_SLT:  alu_control_o = ALU_SLT;
            OP_ADDI: begin
                reg_dst_o     = 1'b0;
                alu_src_o     = 1'b1;
                alu_control_o = ALU_ADD;
            end
            default: begin
                valid_o       = 1'b0;
                reg_dst_o     = 1'b0;
                alu_control_o = 4'b0000;
            end
        endcase
    end
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/WB control FSM with retire counter; SEQ_SINGLE_STEP_EN returns to IDLE after each instruction
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input logic                   clock,
    input logic                   reset,
    multicycle_sequencer_if.slave bus
);
`ifdef SEQ_SINGLE_STEP_EN
    localparam state_t AFTER_INSTR = S_IDLE;
`else
    localparam state_t AFTER_INSTR = S_FETCH;
`endif

    state_t      state_q, state_d;
    logic [15:0] ir_q, count_q;
    logic        ir_write_q, pc_write_q, reg_write_q, reg_dst_q, alu_src_q, busy_q, halted_q;
    logic [3:0]  alu_control_q;
    logic        dec_valid, dec_reg_dst, dec_alu_src;
    logic [3:0]  dec_alu_control;
    logic        ctl_active;

    seq_decode u_decode (
        .op_i          (ir_q[15:12]),
        .valid_o       (dec_valid),
        .reg_dst_o     (dec_reg_dst),
        .alu_src_o     (dec_alu_src),
        .alu_control_o (dec_alu_control)
    );

    // next state; HALT and unused encodings hold until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = bus.run ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (ir_q == HALT_WORD) ? S_HALT : dec_valid ? S_EXEC : AFTER_INSTR;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = AFTER_INSTR;
            default:  state_d = state_q;
        endcase
    end

    assign ctl_active = (state_d == S_EXEC) || (state_d == S_WB);

    // state, latched instruction, saturating retire counter and outputs registered from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ir_q          <= '0;
            count_q       <= '0;
            ir_write_q    <= 1'b0;
            pc_write_q    <= 1'b0;
            reg_write_q   <= 1'b0;
            reg_dst_q     <= 1'b0;
            alu_src_q     <= 1'b0;
            alu_control_q <= '0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            if (state_q == S_FETCH) ir_q <= bus.instr;
            if (state_q == S_WB && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
            ir_write_q    <= state_d == S_FETCH;
            pc_write_q    <= state_d == S_FETCH;
            reg_write_q   <= state_d == S_WB;
            reg_dst_q     <= ctl_active && dec_reg_dst;
            alu_src_q     <= ctl_active && dec_alu_src;
            alu_control_q <= ctl_active ? dec_alu_control : 4'b0000;
            busy_q        <= !(state_d inside {S_IDLE, S_HALT});
            halted_q      <= state_d == S_HALT;
        end
    end

    assign bus.ir_write    = ir_write_q;
    assign bus.pc_write    = pc_write_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.reg_dst     = reg_dst_q;
    assign bus.alu_src     = alu_src_q;
    assign bus.alu_control = alu_control_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed and random programs checked cycle by cycle against an expected-trace model
module tb_multicycle_sequencer;
    typedef struct {
        logic [10:0] v;
        logic [15:0] cnt;
        logic        run;
        logic [15:0] word;
    } step_t;

    localparam logic [5:0] CTL [8] = '{6'b10_0010, 6'b10_0110, 6'b10_0000, 6'b10_0001,
                                       6'b10_1100, 6'b10_1101, 6'b10_0111, 6'b01_0010};
    localparam logic [10:0] V_IDLE  = 11'b0;
    localparam logic [10:0] V_FETCH = {3'b110, 6'b0, 2'b10};
    localparam logic [10:0] V_DEC   = {3'b000, 6'b0, 2'b10};
    localparam logic [10:0] V_HALT  = {3'b000, 6'b0, 2'b01};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_sequencer_if bus();
    multicycle_sequencer dut (.clock(clk), .reset(rst), .bus(bus));

    int          n_cmp = 0;
    int          n_bad = 0;
    step_t       q[$];
    logic [15:0] prog[$];
    logic [15:0] cnt_m = 16'h0;

    function automatic logic [10:0] obs();
        return {bus.ir_write, bus.pc_write, bus.reg_write, bus.reg_dst, bus.alu_src,
                bus.alu_control, bus.busy, bus.halted};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [15:0] rnd();
        return 16'($urandom);
    endfunction

    function automatic logic [15:0] gen();
        logic [15:0] w;
        w = rnd();
        if ($urandom_range(0, 3) != 0) w[15] = 1'b0;
        else if (w == 16'hFFFF || !w[15]) w = 16'h8000;
        return w;
    endfunction

    task automatic check(input string tag, input logic [10:0] ev, input logic [15:0] ec);
        n_cmp++;
        assert (obs() === ev) else begin
            n_bad++;
            $error("FAIL %s controls: got %b want %b", tag, obs(), ev);
        end
        n_cmp++;
        assert (bus.instr_count === ec) else begin
            n_bad++;
            $error("FAIL %s instr_count: got %h want %h", tag, bus.instr_count, ec);
        end
    endtask

    task automatic push(input logic [10:0] v, input logic run, input logic [15:0] word);
        q.push_back('{v, cnt_m, run, word});
    endtask

    task automatic build();
        logic [15:0] w;
        logic [5:0]  c;
        q.delete();
        push(V_IDLE, 1'b1, rnd());
        foreach (prog[i]) begin
            w = prog[i];
            c = CTL[w[14:12]];
            push(V_FETCH, rb(), w);
            push(V_DEC, rb(), rnd());
            if (w == 16'hFFFF) begin
                repeat (4) push(V_HALT, rb(), rnd());
                break;
            end
            if (!w[15]) begin
                push({3'b000, c, 2'b10}, rb(), rnd());
                push({3'b001, c, 2'b10}, rb(), rnd());
                cnt_m = (cnt_m == 16'hFFFF) ? cnt_m : cnt_m + 16'd1;
            end
`ifdef SEQ_SINGLE_STEP_EN
            push(V_IDLE, 1'b1, rnd());
`endif
        end
    endtask

    task automatic play(input string tag);
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            check(tag, s.v, s.cnt);
            bus.run   = s.run;
            bus.instr = s.word;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst     = 1'b1;
        bus.run = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check(tag, V_IDLE, 16'h0);
        end
        rst     = 1'b0;
        bus.run = 1'b0;
        cnt_m   = 16'h0;
    endtask

    initial begin
        bus.run   = 1'b0;
        bus.instr = 16'h0;
        do_reset("reset");
        prog = '{16'h710F, 16'hFFFF};
        build();
        play("addi");
        do_reset("halt_reset");
        prog = '{16'h16C0, 16'h4740, 16'h65FF, 16'hFFFF};
        build();
        play("sub_nor_slt");
        do_reset("reset2");
        prog = '{16'h8000, 16'h710F, 16'hF123, 16'h0ABC, 16'hFFFF};
        build();
        play("undefined");
        do_reset("reset3");
        prog = '{16'h0123};
        build();
        q = q[0:3];
        play("mid_exec");
        rst     = 1'b1;
        bus.run = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mid_exec_reset", V_IDLE, 16'h0);
        end
        rst   = 1'b0;
        cnt_m = 16'h0;
        for (int k = 0; k < 20; k++) begin
            prog.delete();
            repeat ($urandom_range(3, 15)) prog.push_back(gen());
            prog.push_back(16'hFFFF);
            build();
            play("random");
            do_reset("random_reset");
        end
        @(negedge clk);
        force dut.count_q = 16'hFFFD;
        #1 release dut.count_q;
        cnt_m = 16'hFFFD;
        prog = '{16'h0001, 16'h2002, 16'h8888, 16'h3003, 16'h7004, 16'hFFFF};
        build();
        play("saturate");
        do_reset("final_reset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
